// File: rtl/spi_burst_ram.sv
// spi_burst_ram: single-port RAM that sits behind the SPI slave. It decodes
// 2-bit command plus DATA_WIDTH-bit payload words, and keeps independent write
// and read pointers. The pointers can auto-increment so that the SPI side can
// burst data. A rejected command raises a one-cycle err pulse.
module spi_burst_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter bit AUTO_INC   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH+1:0] din,
  input  logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  tx_valid,
  output logic                  err
);

  // Derived from DEPTH. The floor of 1 keeps a DEPTH=1 build legal.
  localparam int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // DEPTH held one bit wider than the payload so that the < DEPTH range check
  // works even when DEPTH == 2**DATA_WIDTH.
  localparam logic [DATA_WIDTH:0]   DEPTH_W = (DATA_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  cmd_e                  cmd;
  logic [DATA_WIDTH-1:0] payload;
  logic                  addr_ok;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic                  wr_vld, rd_vld;

  logic set_wr, set_rd, do_write, do_read, reject;

  assign cmd     = cmd_e'(din[DATA_WIDTH+1:DATA_WIDTH]);
  assign payload = din[DATA_WIDTH-1:0];
  // The full payload takes part in the range check, including the bits above
  // ADDR_WIDTH.
  assign addr_ok = ({1'b0, payload} < DEPTH_W);

  // Pointer step after a data command. A pointer wraps from the last entry
  // to 0, so a non-power-of-two DEPTH never addresses past the array.
  function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] ptr);
    if (!AUTO_INC)    return ptr;
    else if (ptr == LAST) return '0;
    else              return ptr + ADDR_WIDTH'(1);
  endfunction

  // Decode the accepted command into one action, or into a rejection.
  always_comb begin
    // NOTE: every output of this block gets a default first. Without the
    // defaults, a path that does not assign a signal would infer a latch.
    set_wr   = 1'b0;
    set_rd   = 1'b0;
    do_write = 1'b0;
    do_read  = 1'b0;
    reject   = 1'b0;
    if (rx_valid) begin
      case (cmd)
        CMD_WR_ADDR: if (addr_ok) set_wr   = 1'b1; else reject = 1'b1;
        CMD_WR_DATA: if (wr_vld)  do_write = 1'b1; else reject = 1'b1;
        CMD_RD_ADDR: if (addr_ok) set_rd   = 1'b1; else reject = 1'b1;
        CMD_RD_DATA: if (rd_vld)  do_read  = 1'b1; else reject = 1'b1;
      endcase
    end
  end

  // Storage array. It has no reset, so contents survive rst_n.
  // NOTE: the memory is kept out of the reset domain on purpose. A reset here
  // would turn the RAM into a large bank of flops and would break the
  // requirement that data is still readable after a reset.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= payload;
  end

  // Pointers, valid flags and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      wr_vld   <= 1'b0;
      rd_vld   <= 1'b0;
      dout     <= '0;
      tx_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only. Every
      // right-hand side therefore sees the values from before the edge.
      tx_valid <= do_read;
      err      <= reject;

      if (set_wr) begin
        wr_ptr <= payload[ADDR_WIDTH-1:0];
        wr_vld <= 1'b1;
      end else if (do_write) begin
        wr_ptr <= next_ptr(wr_ptr);
      end

      if (set_rd) begin
        rd_ptr <= payload[ADDR_WIDTH-1:0];
        rd_vld <= 1'b1;
      end else if (do_read) begin
        rd_ptr <= next_ptr(rd_ptr);
        dout   <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_spi_burst_ram.sv
// Testbench for spi_burst_ram. Three instances share one clock, one reset and
// one din bus: the default build, a DEPTH=10 build and an AUTO_INC=0 build.
// Each instance has its own rx_valid. Every command pushes its expected
// response to a scoreboard queue. The response is popped and compared one
// cycle later.
module tb_spi_burst_ram;

  localparam int DW = 8;

  typedef enum int {K_OK, K_ERR, K_RD} kind_e;

  typedef struct {
    int          inst;
    logic        tx;
    logic        er;
    logic [DW-1:0] d;
    string       tag;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW+1:0] din = '0;
  logic [2:0]    rxv = '0;

  logic [DW-1:0] dout0, dout1, dout2;
  logic          txv0, txv1, txv2;
  logic          err0, err1, err2;

  exp_t          sb[$];
  logic [DW-1:0] held [3];
  int            total = 0;
  int            bad   = 0;

  always #5 clk = ~clk;

  spi_burst_ram u_def (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rxv[0]),
    .dout(dout0), .tx_valid(txv0), .err(err0)
  );

  spi_burst_ram #(.DATA_WIDTH(8), .DEPTH(10), .AUTO_INC(1'b1)) u_d10 (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rxv[1]),
    .dout(dout1), .tx_valid(txv1), .err(err1)
  );

  spi_burst_ram #(.DATA_WIDTH(8), .DEPTH(256), .AUTO_INC(1'b0)) u_ni (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rxv[2]),
    .dout(dout2), .tx_valid(txv2), .err(err2)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input int inst, input logic tx, input logic er,
                               input logic [DW-1:0] d, input string tag);
    logic [DW-1:0] o_d;
    logic          o_tx, o_er;
    case (inst)
      0:       begin o_d = dout0; o_tx = txv0; o_er = err0; end
      1:       begin o_d = dout1; o_tx = txv1; o_er = err1; end
      default: begin o_d = dout2; o_tx = txv2; o_er = err2; end
    endcase
    check({tag, ".tx_valid"}, {7'd0, o_tx}, {7'd0, tx});
    check({tag, ".err"},      {7'd0, o_er}, {7'd0, er});
    check({tag, ".dout"},     o_d, d);
  endtask

  // Pop one expected response from the queue and compare it with the DUT.
  task automatic pop_and_check();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_underflow observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    check_outputs(e.inst, e.tx, e.er, e.d, e.tag);
  endtask

  // Drive one command on the falling edge. Push the expected response, let
  // the rising edge accept the command, then compare 1 time unit later.
  task automatic send(input int inst, input logic [1:0] cmd, input logic [DW-1:0] pl,
                      input kind_e kind, input logic [DW-1:0] rd_data, input string tag);
    exp_t e;
    @(negedge clk);
    din       = {cmd, pl};
    rxv       = '0;
    rxv[inst] = 1'b1;
    if (kind == K_RD) held[inst] = rd_data;
    e.inst = inst;
    e.tx   = (kind == K_RD);
    e.er   = (kind == K_ERR);
    e.d    = held[inst];
    e.tag  = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    rxv = '0;
    pop_and_check();
  endtask

  // One cycle with rx_valid low. The strobes must drop and dout must hold.
  task automatic idle(input int inst, input string tag);
    exp_t e;
    @(negedge clk);
    rxv    = '0;
    din    = '1;
    e.inst = inst;
    e.tx   = 1'b0;
    e.er   = 1'b0;
    e.d    = held[inst];
    e.tag  = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    pop_and_check();
  endtask

  // Watchdog: the run must always end by itself.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 3; i++) held[i] = '0;

    // Outputs while reset is asserted.
    #12;
    for (int i = 0; i < 3; i++) check_outputs(i, 1'b0, 1'b0, 8'h00, "reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    // A read with no read address after reset is rejected.
    send(0, 2'b11, 8'h00, K_ERR, 8'h00, "rd_no_addr");
    idle(0, "rd_no_addr_err_clears");

    // Single access with the default parameters.
    send(0, 2'b00, 8'h10, K_OK, 8'h00, "single_wa");
    send(0, 2'b01, 8'hA5, K_OK, 8'h00, "single_wd");
    send(0, 2'b10, 8'h10, K_OK, 8'h00, "single_ra");
    send(0, 2'b11, 8'h00, K_RD, 8'hA5, "single_rd");
    idle(0, "single_idle");

    // Burst across the wrap from 0xFF to 0x00.
    send(0, 2'b00, 8'hFE, K_OK, 8'h00, "burst_wa");
    send(0, 2'b01, 8'h11, K_OK, 8'h00, "burst_wd0");
    send(0, 2'b01, 8'h22, K_OK, 8'h00, "burst_wd1");
    send(0, 2'b01, 8'h33, K_OK, 8'h00, "burst_wd2");
    send(0, 2'b10, 8'hFE, K_OK, 8'h00, "burst_ra");
    send(0, 2'b11, 8'h00, K_RD, 8'h11, "burst_rd_fe");
    send(0, 2'b11, 8'h00, K_RD, 8'h22, "burst_rd_ff");
    send(0, 2'b11, 8'h00, K_RD, 8'h33, "burst_rd_00");
    idle(0, "burst_hold");

    // A write followed by a read of the same address in the next cycle.
    send(0, 2'b10, 8'h40, K_OK, 8'h00, "wr2rd_ra");
    send(0, 2'b00, 8'h40, K_OK, 8'h00, "wr2rd_wa");
    send(0, 2'b01, 8'h77, K_OK, 8'h00, "wr2rd_wd");
    send(0, 2'b11, 8'h00, K_RD, 8'h77, "wr2rd_rd");

    // DEPTH=10: range checks and the wrap from 9 to 0.
    send(1, 2'b00, 8'd12,  K_ERR, 8'h00, "d10_wa_oob");
    send(1, 2'b01, 8'h55,  K_ERR, 8'h00, "d10_wd_novld");
    send(1, 2'b00, 8'hF9,  K_ERR, 8'h00, "d10_wa_highbits");
    send(1, 2'b10, 8'd10,  K_ERR, 8'h00, "d10_ra_eq_depth");
    send(1, 2'b00, 8'd9,   K_OK,  8'h00, "d10_wa9");
    send(1, 2'b01, 8'h01,  K_OK,  8'h00, "d10_wd9");
    send(1, 2'b01, 8'h02,  K_OK,  8'h00, "d10_wd0");
    send(1, 2'b10, 8'd9,   K_OK,  8'h00, "d10_ra9");
    send(1, 2'b11, 8'h00,  K_RD,  8'h01, "d10_rd9");
    send(1, 2'b11, 8'h00,  K_RD,  8'h02, "d10_rd0_wrap");

    // AUTO_INC=0: the pointers hold, and entry 6 must not change.
    send(2, 2'b00, 8'd6,  K_OK, 8'h00, "ni_wa6");
    send(2, 2'b01, 8'h66, K_OK, 8'h00, "ni_wd6");
    send(2, 2'b00, 8'd5,  K_OK, 8'h00, "ni_wa5");
    send(2, 2'b01, 8'h01, K_OK, 8'h00, "ni_wd5a");
    send(2, 2'b01, 8'h02, K_OK, 8'h00, "ni_wd5b");
    send(2, 2'b10, 8'd5,  K_OK, 8'h00, "ni_ra5");
    send(2, 2'b11, 8'h00, K_RD, 8'h02, "ni_rd5a");
    send(2, 2'b11, 8'h00, K_RD, 8'h02, "ni_rd5b");
    send(2, 2'b10, 8'd6,  K_OK, 8'h00, "ni_ra6");
    send(2, 2'b11, 8'h00, K_RD, 8'h66, "ni_rd6_untouched");

    // Reset asserted between clock edges in the middle of a read burst.
    send(0, 2'b10, 8'hFE, K_OK, 8'h00, "rst_ra");
    send(0, 2'b11, 8'h00, K_RD, 8'h11, "rst_rd0");
    send(0, 2'b11, 8'h00, K_RD, 8'h22, "rst_rd1");
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs(0, 1'b0, 1'b0, 8'h00, "rst_async");
    for (int i = 0; i < 3; i++) held[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // After the reset the pointers are lost, but the memory contents remain.
    send(0, 2'b11, 8'h00, K_ERR, 8'h00, "post_rst_rd_err");
    send(1, 2'b01, 8'h99, K_ERR, 8'h00, "post_rst_wd_err");
    send(0, 2'b10, 8'hFE, K_OK,  8'h00, "post_rst_ra");
    send(0, 2'b11, 8'h00, K_RD,  8'h11, "post_rst_rd_fe");
    send(0, 2'b11, 8'h00, K_RD,  8'h22, "post_rst_rd_ff");
    idle(0, "post_rst_idle");

    if (sb.size() != 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
